// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, bus widths and CPU port state encoding.
package vga_pkg;
    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int PIX_W        = 8;
    localparam int ADDR_W       = 19;
    localparam logic [ADDR_W-1:0] FB_BASE = '0;
    localparam int FRAME_PIXELS = H_RES * V_RES;
    localparam int SCAN_CNT_W   = $clog2(FRAME_PIXELS + 1);

    typedef enum logic {
        CPU_IDLE = 1'b0,
        CPU_ACK  = 1'b1
    } cpu_state_t;
endpackage

// File: rtl/pixel_fifo.sv
// First-word-fall-through prefetch FIFO: head visible combinationally, push/pop in 1 cycle.
// Flush has priority over push and pop; the caller never pushes when full or pops when empty.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [AW:0]   count
);
    logic [W-1:0]  storage [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush)
            storage[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = (count == '0) ? '0 : storage[rd_ptr];
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: video prefetch vs CPU; mem ops are combinational from the grant.
// CPU is acked one cycle after its grant; video wins when the FIFO level is below LOW_WATER.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LOW_WATER  = 2
) (
    input  logic              clk_50MHz,
    input  logic              clear,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [PIX_W-1:0]  cpu_wdata,
    output logic              cpu_ack,
    output logic [PIX_W-1:0]  cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    cpu_state_t            cpu_state;
    cpu_state_t            cpu_state_nxt;
    logic [ADDR_W-1:0]     scan_addr;
    logic [SCAN_CNT_W-1:0] scan_cnt;
    logic                  scan_active;
    logic                  vid_inflight;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         level;
    logic                  vid_need;
    logic                  vid_urgent;
    logic                  cpu_pending;
    logic                  gnt_vid;
    logic                  gnt_cpu;
    logic                  fifo_pop;
    logic [PIX_W-1:0]      rdata_q;

    // No video fetch in the frame_start cycle: scan_addr is about to restart.
    assign level       = fifo_count + CW'(vid_inflight);
    assign vid_need    = scan_active && !frame_start && (level < CW'(FIFO_DEPTH));
    assign vid_urgent  = vid_need && (level < CW'(LOW_WATER));
    assign cpu_pending = (cpu_state == CPU_IDLE) && cpu_req && !clear;
    assign gnt_vid     = vid_urgent || (vid_need && !cpu_pending);
    assign gnt_cpu     = !gnt_vid && cpu_pending;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (gnt_vid) begin
            mem_addr = scan_addr;
        end else if (gnt_cpu) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk_50MHz or posedge clear) begin
        if (clear)
            cpu_state <= CPU_IDLE;
        else
            cpu_state <= cpu_state_nxt;
    end

    always_comb begin
        cpu_state_nxt = cpu_state;
        cpu_ack       = 1'b0;
        case (cpu_state)
            CPU_IDLE: if (gnt_cpu) cpu_state_nxt = CPU_ACK;
            CPU_ACK: begin
                cpu_ack       = 1'b1;
                cpu_state_nxt = CPU_IDLE;
            end
            default:  cpu_state_nxt = CPU_IDLE;
        endcase
    end

    // Read data is passed straight through during the ack and held afterwards.
    always_ff @(posedge clk_50MHz or posedge clear) begin
        if (clear)
            rdata_q <= '0;
        else if (cpu_ack && !cpu_we)
            rdata_q <= mem_rdata;
    end
    assign cpu_rdata = (cpu_ack && !cpu_we) ? mem_rdata : rdata_q;

    always_ff @(posedge clk_50MHz or posedge clear) begin
        if (clear) begin
            scan_addr    <= FB_BASE;
            scan_cnt     <= '0;
            scan_active  <= 1'b0;
            vid_inflight <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            vid_inflight <= gnt_vid;
            if (pix_pop && fifo_count == '0)
                underflow <= 1'b1;
            if (frame_start) begin
                scan_addr   <= FB_BASE;
                scan_cnt    <= '0;
                scan_active <= 1'b1;
            end else if (gnt_vid) begin
                scan_addr <= scan_addr + ADDR_W'(1);
                scan_cnt  <= scan_cnt + SCAN_CNT_W'(1);
                if (scan_cnt == SCAN_CNT_W'(FRAME_PIXELS - 1))
                    scan_active <= 1'b0;
            end
        end
    end

    assign fifo_pop  = pix_pop && (fifo_count != '0);
    assign pix_valid = (fifo_count != '0);

    // A read in flight when frame_start arrives is dropped by the flush.
    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIX_W)
    ) u_fifo (
        .clk       (clk_50MHz),
        .rst       (clear),
        .flush     (frame_start),
        .push      (vid_inflight),
        .push_data (mem_rdata),
        .pop       (fifo_pop),
        .head      (pix_data),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a synchronous RAM model on the memory port.
module tb_vga_fb_arbiter;
    logic        clk_50MHz = 1'b0;
    logic        clear = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_pop = 1'b0;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        underflow;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [18:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  ram [0:(1<<19)-1];
    int          n_cmp = 0;
    int          n_bad = 0;

    vga_fb_arbiter dut (
        .clk_50MHz   (clk_50MHz),
        .clear       (clear),
        .frame_start (frame_start),
        .pix_pop     (pix_pop),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underflow   (underflow),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    always @(posedge clk_50MHz) begin
        if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(negedge clk_50MHz);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({pix_data, pix_valid, underflow, cpu_ack, cpu_rdata, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: pix_data=%0h pix_valid=%0b underflow=%0b cpu_ack=%0b cpu_rdata=%0h mem_we=%0b mem_addr=%0h mem_wdata=%0h, required all zero",
                     pix_data, pix_valid, underflow, cpu_ack, cpu_rdata, mem_we, mem_addr, mem_wdata);
        end
        tick();
        clear = 1'b0;
        tick();
        n_cmp++;
        if (mem_addr !== 19'h0 || pix_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: mem_addr=%0h pix_valid=%0b, required 0 and 0", mem_addr, pix_valid);
        end
    endtask

    task automatic test_underflow();
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
        tick();
        n_cmp++;
        if (underflow !== 1'b1) begin
            n_bad++;
            $display("FAIL underflow_set: got %0b required 1", underflow);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (underflow !== 1'b1) begin
            n_bad++;
            $display("FAIL underflow_sticky: got %0b required 1", underflow);
        end
        clear = 1'b1;
        #1;
        n_cmp++;
        if (underflow !== 1'b0 || pix_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL underflow_clear: underflow=%0b pix_valid=%0b required 0 0", underflow, pix_valid);
        end
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic test_prefetch();
        logic [18:0] exp_addr [6];
        exp_addr = '{19'h0, 19'h1, 19'h2, 19'h3, 19'h0, 19'h0};
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (mem_addr !== exp_addr[i] || mem_we !== 1'b0) begin
                n_bad++;
                $display("FAIL prefetch_addr[%0d]: mem_addr=%0h mem_we=%0b required %0h 0", i, mem_addr, mem_we, exp_addr[i]);
            end
            tick();
        end
        n_cmp++;
        if (pix_valid !== 1'b1 || pix_data !== 8'h00) begin
            n_bad++;
            $display("FAIL prefetch_head: pix_valid=%0b pix_data=%0h required 1 00", pix_valid, pix_data);
        end
    endtask

    task automatic test_stream();
        logic [7:0] exp;
        for (int k = 0; k < 640; k++) begin
            exp = k[7:0];
            n_cmp++;
            if (pix_valid !== 1'b1 || pix_data !== exp) begin
                n_bad++;
                $display("FAIL stream_pix[%0d]: pix_valid=%0b pix_data=%0h required 1 %0h", k, pix_valid, pix_data, exp);
            end
            pix_pop = 1'b1;
            tick();
            pix_pop = 1'b0;
            tick();
        end
        n_cmp++;
        if (underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_underflow: got %0b required 0", underflow);
        end
        repeat (8) tick();
    endtask

    task automatic test_cpu_write_read();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h100; cpu_wdata = 8'hA5;
        #1;
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 19'h100 || mem_wdata !== 8'hA5 || cpu_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL cpu_write_grant: mem_we=%0b mem_addr=%0h mem_wdata=%0h cpu_ack=%0b required 1 100 a5 0",
                     mem_we, mem_addr, mem_wdata, cpu_ack);
        end
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b1 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL cpu_write_ack: cpu_ack=%0b mem_we=%0b required 1 0", cpu_ack, mem_we);
        end
        cpu_req = 1'b0;
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL cpu_ack_single: got %0b required 0", cpu_ack);
        end
        cpu_req = 1'b1; cpu_we = 1'b0;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0 || mem_addr !== 19'h100) begin
            n_bad++;
            $display("FAIL cpu_read_grant: mem_we=%0b mem_addr=%0h required 0 100", mem_we, mem_addr);
        end
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
            n_bad++;
            $display("FAIL cpu_read_ack: cpu_ack=%0b cpu_rdata=%0h required 1 a5", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b0 || cpu_rdata !== 8'hA5) begin
            n_bad++;
            $display("FAIL cpu_rdata_hold: cpu_ack=%0b cpu_rdata=%0h required 0 a5", cpu_ack, cpu_rdata);
        end
    endtask

    task automatic test_cpu_contention();
        logic [18:0] exp_addr [6];
        logic [7:0]  exp;
        exp_addr = '{19'h0, 19'h1, 19'h100, 19'h2, 19'h3, 19'h0};
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h100;
        #1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (mem_addr !== exp_addr[i] || mem_we !== 1'b0) begin
                n_bad++;
                $display("FAIL contention_addr[%0d]: mem_addr=%0h mem_we=%0b required %0h 0", i, mem_addr, mem_we, exp_addr[i]);
            end
            if (i == 3) begin
                n_cmp++;
                if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
                    n_bad++;
                    $display("FAIL contention_ack: cpu_ack=%0b cpu_rdata=%0h required 1 a5", cpu_ack, cpu_rdata);
                end
                cpu_req = 1'b0;
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            exp = k[7:0];
            n_cmp++;
            if (pix_valid !== 1'b1 || pix_data !== exp) begin
                n_bad++;
                $display("FAIL contention_order[%0d]: pix_valid=%0b pix_data=%0h required 1 %0h", k, pix_valid, pix_data, exp);
            end
            pix_pop = 1'b1;
            tick();
            pix_pop = 1'b0;
            tick();
        end
        repeat (8) tick();
    endtask

    task automatic test_frame_restart();
        bit seen;
        ram[0] = 8'h5A;
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
        n_cmp++;
        if (mem_addr !== 19'h8 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_refetch: mem_addr=%0h mem_we=%0b required 8 0", mem_addr, mem_we);
        end
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_cmp++;
        if (pix_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_flush: pix_valid=%0b pix_data=%0h required 0", pix_valid, pix_data);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = pix_valid;
        end
        n_cmp++;
        if (!seen || pix_data !== 8'h5A) begin
            n_bad++;
            $display("FAIL restart_first_pixel: pix_valid=%0b pix_data=%0h required 1 5a", pix_valid, pix_data);
        end
        repeat (8) tick();
    endtask

    task automatic test_clear_during_ack();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h200; cpu_wdata = 8'h3C;
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_pre_ack: cpu_ack=%0b required 1", cpu_ack);
        end
        clear = 1'b1;
        cpu_req = 1'b0;
        #1;
        n_cmp++;
        if (cpu_ack !== 1'b0 || mem_we !== 1'b0 || pix_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_in_ack: cpu_ack=%0b mem_we=%0b pix_valid=%0b required 0 0 0", cpu_ack, mem_we, pix_valid);
        end
        tick();
        clear = 1'b0;
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_no_late_ack: cpu_ack=%0b required 0", cpu_ack);
        end
        cpu_req = 1'b1; cpu_we = 1'b0;
        #1;
        n_cmp++;
        if (mem_addr !== 19'h200 || cpu_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_idle_grant: mem_addr=%0h cpu_ack=%0b required 200 0", mem_addr, cpu_ack);
        end
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h3C) begin
            n_bad++;
            $display("FAIL clear_idle_read: cpu_ack=%0b cpu_rdata=%0h required 1 3c", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << 19); i++)
            ram[i] = i[7:0];
        test_reset();
        test_underflow();
        test_prefetch();
        test_stream();
        test_cpu_write_read();
        test_cpu_contention();
        test_frame_restart();
        test_clear_during_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares the single-port framebuffer RAM between the VGA scanout path and the CPU data port.
- Runs a scanout address counter and prefetches pixels into a small FIFO. The pixel generator pops one word per visible pixel.
- The CPU gets the remaining memory slots through a req/ack handshake.
- Sits between the CPU bus, the framebuffer RAM and the VGA bit generator.

Parameters:
H_RES, 640, visible pixels per line
V_RES, 480, visible lines per frame
PIX_W, 8, pixel word width (RGB332)
ADDR_W, 19, framebuffer address width
FB_BASE, 0, word address of pixel (0,0)
FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, >=4)
LOW_WATER, 2, fill level below which video fetch is urgent

Ports:
clk_50MHz  in  1  system clock
clear  in  1  asynchronous active-high reset
frame_start  in  1  one-cycle pulse at start of vertical blank; restarts scanout
pix_pop  in  1  one-cycle pulse: consume one pixel (asserted at most every 2nd cycle)
pix_data  out  PIX_W  head-of-FIFO pixel, valid when pix_valid
pix_valid  out  1  FIFO non-empty
underflow  out  1  sticky: pop seen while FIFO empty
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU word address; stable while cpu_req
cpu_wdata  in  PIX_W  CPU write data; stable while cpu_req
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  PIX_W  read data, valid in the cpu_ack cycle, held after
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  PIX_W  RAM write data
mem_rdata  in  PIX_W  RAM read data, valid one cycle after address (synchronous RAM)

Behaviour:
- Reset (clear=1, async):
  - Outputs: pix_data=0, pix_valid=0, underflow=0, cpu_ack=0, cpu_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Internal: FIFO empty, scan_addr=FB_BASE, scan_cnt=0, scan_active=0, CPU FSM=IDLE.
- Scanout:
  - frame_start sets scan_addr=FB_BASE, scan_cnt=0, scan_active=1, flushes the FIFO and marks any in-flight video read as discarded.
  - Each video fetch issues mem_addr=scan_addr, then increments scan_addr and scan_cnt.
  - scan_active clears once scan_cnt reaches H_RES*V_RES.
- Arbitration is one memory op per cycle, with level = FIFO count + in-flight video reads:
  - vid_need = scan_active && level < FIFO_DEPTH
  - vid_urgent = vid_need && level < LOW_WATER
  - Grant video if vid_urgent, or if vid_need && CPU FSM not in REQ-pending state. Else grant CPU if the FSM is in IDLE with cpu_req=1. Else no op (mem_we=0).
- Video data path: mem_rdata is pushed into the FIFO the cycle after a video grant, unless discarded by an intervening frame_start.
- CPU FSM:
  - IDLE: on cpu_req, if granted this cycle, drive mem_addr/mem_we/mem_wdata and go to ACK; otherwise stay pending.
  - ACK: cpu_ack=1 for one cycle; on a read, cpu_rdata<=mem_rdata. Return to IDLE. cpu_req is ignored in the ACK cycle, so there is no back-to-back grant.
  - Latency is grant+1 cycle. With an idle video side, a request is acked 2 cycles after it is asserted (grant cycle, ack cycle).
- FIFO pop:
  - pix_pop with count>0 removes the head; pix_data shows the new head combinationally from FIFO storage.
  - pix_pop with count==0 sets underflow (sticky until clear) and leaves the FIFO unchanged.
  - Push and pop in the same cycle keep count unchanged.
- Simultaneous events:
  - frame_start together with pix_pop or a push: the flush wins and the FIFO ends empty.
  - frame_start does not affect an in-progress CPU access.
  - A CPU write to an address already prefetched is not reflected in the FIFO; this is accepted.
- Bandwidth guarantee: pops occur at most every 2nd cycle, so video never underflows with LOW_WATER>=2. The CPU is granted within 3 cycles whenever level >= LOW_WATER.
- The arbiter does not gate pix_pop with blanking; the pixel generator must pop only when bright.

Decomposition:
- Shared package vga_pkg: H_RES, V_RES, PIX_W, ADDR_W, FB_BASE, FRAME_PIXELS=H_RES*V_RES, CPU FSM state encoding (IDLE, ACK).
- One sub-module: pixel_fifo (sync FIFO, FIFO_DEPTH x PIX_W, push/pop/flush, count, first-word-fall-through).

Test Plan:
- Reset then frame_start, no pops, RAM[i]=i[7:0] → 4 video reads at addr 0..3, then fetching stops; pix_valid=1, pix_data=0x00.
- Continuous pix_pop every 2nd cycle for 640 pops → pix_data sequence 0x00..0xFF repeating, underflow stays 0.
- CPU write addr 0x100 data 0xA5 while FIFO full → grant immediately, cpu_ack 2 cycles after cpu_req rises. A following CPU read of 0x100 acks with cpu_rdata=0xA5.
- CPU req held with level < LOW_WATER → video wins. The CPU is granted as soon as level >= LOW_WATER, and the video fetch order is unbroken.
- pix_pop with FIFO empty (before frame_start) → underflow=1, and it stays 1 until clear.
- frame_start mid-frame with a read in flight → FIFO empties, the stale word is not pushed, and next pix_data = RAM[FB_BASE]. Assert clear during a CPU ACK → cpu_ack=0 immediately, FSM=IDLE.
